// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the program counter, runs a
//                request/grant/response handshake to instruction memory,
//                accepts redirects from execute and holds its output while
//                the downstream decoder stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory interface
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    // control from execute / downstream
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    // fetched instruction towards decode
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] c_INSTR_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            w_req;
    logic            w_capture;
    logic            w_consume;

    logic            r_instr_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_pc_plus4;

    // PC arithmetic wraps naturally at 2^XLEN; redirect targets are forced
    // to word alignment, the low bits only feed the misalignment flag.
    assign w_pc_inc      = r_pc + c_INSTR_BYTES;
    assign w_redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

    // Decode consumes the held instruction in any unstalled cycle.
    assign w_consume = r_instr_valid & ~stall;

    // Next-state, next-PC and capture decision; redirect overrides the
    // normal handshake flow but must still account for an in-flight fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_req       = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop) begin
                        // Response belongs to a fetch made obsolete by a
                        // redirect; the PC already holds the new target.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = stall ? S_HOLD : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (redirect) begin
            w_capture   = 1'b0;
            w_pc_nxt    = w_redirect_pc;
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
            // A fetch is still outstanding: wait for its response and throw
            // it away, since only one request may be in flight at a time.
            if ((r_state == S_WAIT) && !imem_rvalid) begin
                w_state_nxt = S_WAIT;
                w_drop_nxt  = 1'b1;
            end
            if ((r_state == S_REQ) && imem_gnt) begin
                w_state_nxt = S_WAIT;
                w_drop_nxt  = 1'b1;
            end
        end
    end

    // FSM state, program counter and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Output instruction registers: flushed by redirect, loaded on capture,
    // valid cleared once decode consumes the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_pc_plus4    <= '0;
        end else if (redirect) begin
            r_instr_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr_valid <= 1'b1;
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_pc_plus4    <= w_pc_inc;
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

    // Outputs are forced low while reset is asserted; the fetch address
    // always reflects the current PC.
    assign imem_req     = w_req & ~rst;
    assign imem_addr    = r_pc;
    assign instr_valid  = r_instr_valid & ~rst;
    assign instr        = rst ? '0 : r_instr;
    assign op           = instr[6:0];
    assign instr_pc     = rst ? '0 : r_instr_pc;
    assign pc_plus4     = rst ? '0 : r_pc_plus4;
    assign misalign_err = redirect & (|redirect_target[1:0]) & ~rst;

endmodule
`default_nettype wire
